// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them into a
// 64-entry instruction memory, one word per cycle, with program-end tracking.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [1:0]  op,
    input  logic [3:0]  cond,
    input  logic [3:0]  cmd,
    input  logic        i_bit,
    input  logic        s_bit,
    input  logic        mul,
    input  logic        u_bit,
    input  logic        l_bit,
    input  logic        link,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [1:0]  sh_type,
    input  logic [4:0]  shamt,
    input  logic [23:0] imm,
    input  logic        flush,
    output logic        imem_we,
    output logic [5:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic [6:0]  count,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_DATA   = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_ILL    = 2'b11;
    localparam logic [3:0] COND_ILL  = 4'b1111;
    localparam logic [6:0] DEPTH     = 7'd64;

    state_e      state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;

    logic        xfer_s;
    logic        legal_s;
    logic        final_s;
    logic [11:0] shreg_s;
    logic [11:0] op2_s;
    logic [31:0] word_s;

    function automatic logic [11:0] shifted_reg(input logic [4:0] sa,
                                                input logic [1:0] st,
                                                input logic [3:0] m);
        return {sa, st, 1'b0, m};
    endfunction

    function automatic logic [31:0] enc_data(input logic [3:0]  c,
                                             input logic [3:0]  cm,
                                             input logic        ib,
                                             input logic        sb,
                                             input logic        ml,
                                             input logic [3:0]  n,
                                             input logic [3:0]  d,
                                             input logic [3:0]  m,
                                             input logic [11:0] op2);
        logic [31:0] w;
        // Multiply reuses the DATA opcode space: rd moves to [19:16], rn to [3:0].
        if (ml) begin
            w = {c, 7'd0, sb, d, 4'd0, m, 4'b1001, n};
        end else begin
            w = {c, OP_DATA, ib, cm, sb, n, d, op2};
        end
        return w;
    endfunction

    function automatic logic [31:0] enc_mem(input logic [3:0]  c,
                                            input logic        ib,
                                            input logic        ub,
                                            input logic        lb,
                                            input logic [3:0]  n,
                                            input logic [3:0]  d,
                                            input logic [11:0] off);
        return {c, OP_MEM, ~ib, 1'b1, ub, 2'b00, lb, n, d, off};
    endfunction

    function automatic logic [31:0] enc_branch(input logic [3:0]  c,
                                               input logic        lk,
                                               input logic [23:0] im);
        return {c, OP_BRANCH, 1'b1, lk, im};
    endfunction

    assign in_ready = ready_q & ~flush;
    assign xfer_s   = in_valid & in_ready;
    assign legal_s  = (op != OP_ILL) && (cond != COND_ILL);
    assign shreg_s  = shifted_reg(shamt, sh_type, rm);
    assign op2_s    = i_bit ? imm[11:0] : shreg_s;

    // Word encoder: selects the field layout for the current opcode.
    always_comb begin
        word_s = 32'h0000_0000;
        case (op)
            OP_DATA:   word_s = enc_data(cond, cmd, i_bit, s_bit, mul, rn, rd, rm, op2_s);
            OP_MEM:    word_s = enc_mem(cond, i_bit, u_bit, l_bit, rn, rd, op2_s);
            OP_BRANCH: word_s = enc_branch(cond, link, imm);
            default:   word_s = 32'h0000_0000;
        endcase
    end

    // Next-state and output logic; flush overrides any transfer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        final_s = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            count_d = 7'd0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (xfer_s) begin
                        final_s = in_last || (legal_s && (count_q == (DEPTH - 7'd1)));
                        if (legal_s) begin
                            we_d    = 1'b1;
                            addr_d  = count_q[5:0];
                            wdata_d = word_s;
                            count_d = count_q + 7'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (final_s) begin
                            state_d = ST_DONE;
                        end else if (legal_s) begin
                            state_d = ST_FILL;
                        end else begin
                            state_d = state_q;
                        end
                        done_d = final_s;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
        ready_d = (state_d != ST_DONE) && (count_d != DEPTH);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= 7'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 6'd0;
            wdata_q <= 32'h0000_0000;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1; in_ready  out  1. A transfer occurs when both are high on a clk edge.
REQ-004 SHALL have: in_last  in  1  marks the final word of a program.
REQ-005 SHALL have field inputs:
- op  2  (00 DATA, 01 MEMORY, 10 BRANCH, 11 illegal)
- cond  4; cmd  4; i_bit  1; s_bit  1; mul  1
- u_bit  1; l_bit  1; link  1
- rn  4; rd  4; rm  4; sh_type  2; shamt  5; imm  24
REQ-006 SHALL have: flush  in  1  synchronous program restart.
REQ-007 SHALL have IMEM write port outputs:
- imem_we  1
- imem_addr  6
- imem_wdata  32
REQ-008 SHALL have status outputs:
- count  7  number of words accepted
- done  1  one-cycle pulse
- err  1  sticky

Function
REQ-009 Every encoded word SHALL set [31:28]=cond and [27:26]=op.
REQ-010 DATA with i_bit=1 SHALL encode:
- [25]=1, [24:21]=cmd, [20]=s_bit
- [19:16]=rn, [15:12]=rd, [11:0]=imm[11:0]
REQ-011 DATA with i_bit=0 SHALL encode:
- [25]=0, [24:21]=cmd, [20]=s_bit, [19:16]=rn, [15:12]=rd
- [11:7]=shamt, [6:5]=sh_type, [4]=0, [3:0]=rm
REQ-012 DATA with mul=1 SHALL encode, ignoring cmd and i_bit:
- [27:21]=0, [20]=s_bit, [19:16]=rd, [15:12]=0
- [11:8]=rm, [7:4]=1001, [3:0]=rn
REQ-013 MEMORY SHALL encode:
- [25]=~i_bit, [24]=1, [23]=u_bit, [22:21]=00, [20]=l_bit
- [19:16]=rn, [15:12]=rd
- [11:0] = imm[11:0] when i_bit=1; otherwise {shamt, sh_type, 0, rm}
REQ-014 BRANCH SHALL encode [25]=1, [24]=link, [23:0]=imm[23:0].
REQ-015 A transfer with op=11 or cond=1111 SHALL be illegal:
- err is set; no IMEM write occurs; count is unchanged.
- An illegal transfer with in_last=1 still ends the program (REQ-020).
REQ-016 Latency SHALL be one cycle. For a legal transfer at edge N, imem_we=1 with the encoded imem_wdata is presented during the cycle after edge N.
REQ-017 imem_addr for a word SHALL equal count before the increment; count SHALL increment at edge N.
REQ-018 Back-to-back transfers SHALL be sustained at one word per cycle; imem_we SHALL be 0 in any cycle not following a legal transfer.
REQ-019 The FSM SHALL have states IDLE, FILL, DONE:
- IDLE→FILL on the first legal transfer.
- IDLE or FILL→DONE on a transfer with in_last=1, or on the transfer that makes count=64.
- DONE→IDLE only on flush.
REQ-020 done SHALL pulse high for one cycle, coincident with the final write. If the final transfer is illegal, done pulses in the cycle after that transfer.
REQ-021 in_ready SHALL be low in DONE, while flush=1, and when count=64. It SHALL be high otherwise. The address never wraps and IMEM is never overwritten.
REQ-022 flush SHALL have priority over in_valid. It SHALL:
- clear count and err;
- cancel any write pending for the next cycle (imem_we=0 next cycle);
- return the FSM to IDLE.
REQ-023 Field inputs SHALL be sampled only at transfer edges; they SHALL be ignored otherwise.

Reset
REQ-024 rst_n low SHALL asynchronously force the following, regardless of clk:
- FSM to IDLE, count=0;
- imem_we=0, imem_addr=0, imem_wdata=0;
- done=0, err=0, in_ready=0.
REQ-025 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-026 Reset asserted mid-stream SHALL discard any pending write.

Verification
REQ-027 DATA ADD, imm, S=1: cond=1110 op=00 i=1 cmd=0100 s=1 rn=1 rd=2 imm=0x0FF → next cycle imem_we=1, addr=0, wdata=0xE29120FF, count=1.
REQ-028 MUL plus BRANCH-link back-to-back:
- MUL with cond=1110 rd=3 rm=4 rn=5 s=0 → wdata=0xE0030495.
- Next cycle, op=10 link=1 imm=0x000010 → wdata=0xEB000010 at addr=1.
REQ-029 Illegal op=11: err=1, no write, count unchanged. A following legal word is written at the unchanged address.
REQ-030 Fill 64 words with in_last=0 → in_ready=0 after the 64th transfer; done pulses with the addr=63 write; FSM is in DONE.
REQ-031 flush asserted together with in_valid in FILL → no write next cycle; count=0, err=0; next word written at addr=0.
REQ-032 rst_n pulled low during streaming → all outputs reach their reset values immediately; no write in the following cycle.
